// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_if
//  Description : Instruction-memory request/response bus for the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ready, input imem_rdata);
    modport slave  (input  imem_req, input imem_addr,
                    output imem_ready, output imem_rdata);
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : IF stage with IF/ID register, one-entry skid buffer, redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              stall,
    input  wire logic              branch_taken,
    input  wire logic [31:0]       branch_target,
    instruction_fetch_if.master    bus,
    output logic [31:0]            if_id_instr,
    output logic [31:0]            if_id_pc_plus4,
    output logic                   if_id_valid,
    output logic [5:0]             opcode
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_HELD  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc_plus4;
    logic        r_if_id_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc_plus4;
    logic        r_skid_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_pc;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_branch_pc = branch_target & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= c_IDLE;
            r_pc             <= RESET_PC;
            r_if_id_instr    <= 32'd0;
            r_if_id_pc_plus4 <= 32'd0;
            r_if_id_valid    <= 1'b0;
            r_skid_instr     <= 32'd0;
            r_skid_pc_plus4  <= 32'd0;
            r_skid_valid     <= 1'b0;
        end else if (branch_taken) begin
            // Redirect wins over everything; any in-flight or buffered word is dropped.
            r_state       <= c_FETCH;
            r_pc          <= w_branch_pc;
            r_if_id_valid <= 1'b0;
            r_skid_valid  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_state <= c_FETCH;
                end
                c_FETCH: begin
                    if (bus.imem_ready && !stall) begin
                        r_if_id_instr    <= bus.imem_rdata;
                        r_if_id_pc_plus4 <= w_pc_plus4;
                        r_if_id_valid    <= 1'b1;
                        r_pc             <= w_pc_plus4;
                    end else if (bus.imem_ready && stall) begin
                        r_skid_instr    <= bus.imem_rdata;
                        r_skid_pc_plus4 <= w_pc_plus4;
                        r_skid_valid    <= 1'b1;
                        r_state         <= c_HELD;
                    end else if (!stall) begin
                        r_if_id_valid <= 1'b0;
                    end
                end
                c_HELD: begin
                    if (!stall) begin
                        r_if_id_instr    <= r_skid_instr;
                        r_if_id_pc_plus4 <= r_skid_pc_plus4;
                        r_if_id_valid    <= r_skid_valid;
                        r_skid_valid     <= 1'b0;
                        r_pc             <= w_pc_plus4;
                        r_state          <= c_FETCH;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req   = (r_state == c_FETCH);
    assign bus.imem_addr  = r_pc;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_pc_plus4 = r_if_id_pc_plus4;
    assign if_id_valid    = r_if_id_valid;
    assign opcode         = r_if_id_instr[31:26];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Scoreboard bench for instruction_fetch (stall, bubble, branch, reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        rst2;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ready;

    logic [31:0] if_id_instr,  if_id_pc_plus4;
    logic        if_id_valid;
    logic [5:0]  opcode;
    logic [31:0] if_id_instr2, if_id_pc_plus4_2;
    logic        if_id_valid2;
    logic [5:0]  opcode2;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb[$];
    logic        adv;

    instruction_fetch_if imem ();
    instruction_fetch_if imem2 ();

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem.imem_ready  = ready;
    assign imem.imem_rdata  = mem_word(imem.imem_addr);
    assign imem2.imem_ready = 1'b1;
    assign imem2.imem_rdata = mem_word(imem2.imem_addr);

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .bus            (imem.master),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .opcode         (opcode)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk            (clk),
        .reset          (rst2),
        .stall          (1'b0),
        .branch_taken   (1'b0),
        .branch_target  (32'd0),
        .bus            (imem2.master),
        .if_id_instr    (if_id_instr2),
        .if_id_pc_plus4 (if_id_pc_plus4_2),
        .if_id_valid    (if_id_valid2),
        .opcode         (opcode2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        sb.push_back({mem_word(a), a + 32'd4});
    endtask

    // Monitor: an instruction is new on IF/ID only after an edge that advanced the stage.
    always @(posedge clk) adv <= !reset && !stall && !branch_taken;

    always @(negedge clk) begin
        logic [63:0] e;
        if (adv && if_id_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr: got %h expected none", if_id_instr);
            end else begin
                e = sb.pop_front();
                check("ifid_instr", if_id_instr, e[63:32]);
                check("ifid_pc_plus4", if_id_pc_plus4, e[31:0]);
                check("ifid_opcode", {26'd0, opcode}, {26'd0, e[63:58]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rst2 = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'd0; ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_instr", if_id_instr, 32'd0);
        check("rst_pc_plus4", if_id_pc_plus4, 32'd0);
        check("rst_req", {31'd0, imem.imem_req}, 32'd0);
        check("rst_addr", imem.imem_addr, 32'd0);
        reset = 1'b0; rst2 = 1'b0;
        #1;
        check("idle_req", {31'd0, imem.imem_req}, 32'd0);

        // Sequential fetch from RESET_PC
        @(negedge clk);
        check("fetch0_req", {31'd0, imem.imem_req}, 32'd1);
        check("fetch0_addr", imem.imem_addr, 32'h0);
        check("wrap_addr0", imem2.imem_addr, 32'hFFFF_FFFC);
        check("wrap_req", {31'd0, imem2.imem_req}, 32'd1);
        push_exp(32'h0);
        @(negedge clk);
        check("fetch1_addr", imem.imem_addr, 32'h4);
        check("wrap_addr1", imem2.imem_addr, 32'h0);
        check("wrap_pc_plus4", if_id_pc_plus4_2, 32'h0);
        check("wrap_instr", if_id_instr2, mem_word(32'hFFFF_FFFC));
        check("wrap_valid", {31'd0, if_id_valid2}, 32'd1);
        push_exp(32'h4);
        @(negedge clk);
        check("fetch2_addr", imem.imem_addr, 32'h8);
        check("wrap_pc_plus4_b", if_id_pc_plus4_2, 32'h4);
        rst2 = 1'b1;

        // Stall coincident with accepted fetch at 0x8
        stall = 1'b1;
        push_exp(32'h8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_req", {31'd0, imem.imem_req}, 32'd0);
            check("held_addr", imem.imem_addr, 32'h8);
            check("held_instr", if_id_instr, mem_word(32'h4));
            check("held_pc_plus4", if_id_pc_plus4, 32'h8);
            check("held_valid", {31'd0, if_id_valid}, 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        check("release_addr", imem.imem_addr, 32'hC);
        check("release_req", {31'd0, imem.imem_req}, 32'd1);
        push_exp(32'hC);
        @(negedge clk);
        check("pre_bubble_addr", imem.imem_addr, 32'h10);

        // Memory not ready for two cycles at 0x10
        ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bubble_valid", {31'd0, if_id_valid}, 32'd0);
            check("bubble_addr", imem.imem_addr, 32'h10);
            check("bubble_instr", if_id_instr, mem_word(32'hC));
            check("bubble_opcode", {26'd0, opcode}, {26'd0, mem_word(32'hC) >> 26});
        end
        ready = 1'b1;
        push_exp(32'h10);
        @(negedge clk);
        check("post_bubble_addr", imem.imem_addr, 32'h14);

        // Enter HELD at 0x14, then redirect while still stalled
        stall = 1'b1;
        @(negedge clk);
        check("held2_req", {31'd0, imem.imem_req}, 32'd0);
        branch_taken = 1'b1; branch_target = 32'h0000_0103;
        @(negedge clk);
        check("branch_addr", imem.imem_addr, 32'h100);
        check("branch_valid", {31'd0, if_id_valid}, 32'd0);
        check("branch_req", {31'd0, imem.imem_req}, 32'd1);
        branch_taken = 1'b0; stall = 1'b0;
        push_exp(32'h100);
        @(negedge clk);
        check("post_branch_addr", imem.imem_addr, 32'h104);

        // Async reset pulse between edges while HELD
        stall = 1'b1;
        @(negedge clk);
        check("held3_req", {31'd0, imem.imem_req}, 32'd0);
        check("held3_instr", if_id_instr, mem_word(32'h100));
        #2 reset = 1'b1;
        #1;
        check("async_valid", {31'd0, if_id_valid}, 32'd0);
        check("async_instr", if_id_instr, 32'd0);
        check("async_pc_plus4", if_id_pc_plus4, 32'd0);
        check("async_req", {31'd0, imem.imem_req}, 32'd0);
        check("async_addr", imem.imem_addr, 32'd0);
        check("async_opcode", {26'd0, opcode}, 32'd0);
        #1 reset = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("restart_req", {31'd0, imem.imem_req}, 32'd1);
        check("restart_addr", imem.imem_addr, 32'h0);
        push_exp(32'h0);
        @(negedge clk);
        check("restart_addr1", imem.imem_addr, 32'h4);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
